serial_parity_checker: RTL
==========================

// Module: serial_parity_checker
// PURPOSE
//   Multi-lane serial parity accumulator and checker. Each of LANES serial lanes carries a frame
//   of FRAME_LEN data bits followed by one parity bit. Per lane, the block keeps a running
//   even/odd count of ones, compares it to the received parity bit and flags mismatches.
//   Sits between a serial receiver front end and the frame-accept logic.
// PARAMETERS
//   LANES      4    number of parallel serial lanes, 1..32
//   FRAME_LEN  64   data bits per frame, excluding the parity bit; must be >= 1
//   CNT_W      $clog2(FRAME_LEN+1)   localparam; width of bit_count
// PORTS
//   clock       in   1          rising-edge clock
//   reset       in   1          asynchronous, active-high reset
//   start       in   1          frame-start strobe; honoured only in IDLE
//   abort       in   1          discards the current frame and returns to IDLE
//   odd_mode    in   1          0 = even parity, 1 = odd parity; sampled on the start cycle
//   in_valid    in   1          in_bits are valid this cycle
//   in_bits     in   LANES      one serial bit per lane
//   run_par     out  LANES      registered running XOR of the data bits accepted so far
//   bit_count   out  CNT_W      number of data bits accepted in the current frame
//   busy        out  1          high in DATA and PAR states
//   done        out  1          1-cycle pulse when a frame completes
//   parity_err  out  LANES      per-lane mismatch; valid from done, held until next start
// BEHAVIOUR
//   - Reset (async): state=IDLE; run_par, bit_count, parity_err = 0; busy, done = 0; mode register = 0.
//   - IDLE: start=1 -> DATA. Same edge: run_par<=0, bit_count<=0, parity_err<=0, mode<=odd_mode.
//     The start cycle carries no data; in_valid is ignored in IDLE.
//   - DATA: on each in_valid=1 cycle: run_par <= run_par ^ in_bits; bit_count <= bit_count+1.
//     When the accepted bit makes bit_count==FRAME_LEN, go to PAR.
//     in_valid=0 is a stall: no state change.
//   - PAR: on in_valid=1: parity_err <= in_bits ^ run_par ^ {LANES{mode}}; go to DONE.
//     Even mode: the parity bit must equal the XOR of the data bits. Odd mode: its inverse.
//   - DONE: done=1 for exactly this cycle, then unconditionally -> IDLE. Start during DONE is ignored.
//   - Latency: done rises 1 cycle after the parity bit is accepted. Minimum frame is FRAME_LEN+3 cycles
//     from start to done-low.
//   - start in DATA/PAR/DONE: ignored, with no effect on accumulation.
//   - abort (any state except IDLE): next state IDLE; run_par, bit_count, parity_err cleared;
//     no done pulse. abort has priority over in_valid and start in the same cycle.
//     abort in IDLE: no effect, and it blocks start that cycle.
//   - odd_mode changes mid-frame have no effect; only the value sampled at start is used.
//   - bit_count never exceeds FRAME_LEN. run_par holds its final value until the next start or abort.
//   - Illegal state encoding: recover to IDLE on the next edge, with outputs as after reset.
//   - FSM: 2-bit state, registered next-state logic, non-blocking assignments only.
// STRUCTURE
//   - parity_defs.vh (shared include): state encodings ST_IDLE=2'b00, ST_DATA=2'b01, ST_PAR=2'b10,
//     ST_DONE=2'b11, plus the PAR_EVEN/PAR_ODD mode constants.
//   - Top level holds the FSM, bit counter and mode register.
//   - Sub-module parity_lane: one lane's run_par flop and err flop, with inputs clr, acc_en,
//     chk_en, mode and bit. Instantiated LANES times in a generate loop.
// TESTING
//   1. Reset mid-frame: assert reset after 10 accepted bits -> all outputs 0 immediately, state IDLE,
//      no done pulse.
//   2. LANES=4, FRAME_LEN=8, even mode; lane0 = 8'b1011_0001 (4 ones), parity bit 0 -> parity_err[0]=0
//      and run_par[0]=0. Lane1 data 8'b0000_0001 with parity bit 0 -> parity_err[1]=1, done pulses once.
//   3. Odd mode, all lanes data 8'hFF, parity bit 1 -> parity_err=4'b0000. Parity bit 0 -> 4'b1111.
//   4. in_valid gaps: insert 3 stall cycles inside a frame -> bit_count freezes, result matches the
//      no-stall run, done is delayed exactly 3 cycles.
//   5. abort at bit_count=5 together with in_valid and start -> IDLE, bit_count=0, no done;
//      a following start runs a clean frame.
//   6. Random regression: 200 frames, FRAME_LEN=64, random odd_mode and stalls -> parity_err equals
//      a model of popcount%2 ^ mode ^ parity bit; start pulses while busy never alter the result.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker.
// Holds the FSM state encoding and the parity-mode constants used by the
// top level (serial_parity_checker) and its lane slice.
package serial_parity_checker_pkg;

  // All four 2-bit codes are assigned, so the state register has no
  // unreachable encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PAR  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_parity_lane.sv
// One lane of the parity checker: running XOR of accepted data bits and the
// mismatch flag produced when the parity bit arrives.
// Ports: clock/reset; clr (synchronous clear), acc_en (fold data_bit into
// run_par), chk_en (compare data_bit as parity bit), mode (0 even, 1 odd);
// outputs run_par and err, both registered.
module serial_parity_checker_parity_lane
  import serial_parity_checker_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic acc_en,
  input  logic chk_en,
  input  logic mode,
  input  logic data_bit,
  output logic run_par,
  output logic err
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_par <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      run_par <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (acc_en) begin
        run_par <= run_par ^ data_bit;
      end
      // In odd mode a correct parity bit is the inverse of the data XOR,
      // so folding mode in makes err=0 mean "parity good" in both modes.
      if (chk_en) begin
        err <= data_bit ^ run_par ^ mode;
      end
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Multi-lane serial parity accumulator/checker: LANES lanes each carry
// FRAME_LEN data bits followed by one parity bit.
// Ports: clock, reset (async, active high), start, abort, odd_mode, in_valid,
// in_bits[LANES]; outputs run_par, bit_count, busy, done, parity_err.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter  int LANES     = 4,
  parameter  int FRAME_LEN = 64,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             odd_mode,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_bits,
  output logic [LANES-1:0] run_par,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             done,
  output logic [LANES-1:0] parity_err
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  state_t state;
  logic   mode;

  // abort only acts outside IDLE; in IDLE it merely suppresses start.
  logic go;
  logic kill;
  logic lane_clr;
  logic acc_en;
  logic chk_en;

  assign go       = (state == ST_IDLE) && start && !abort;
  assign kill     = (state != ST_IDLE) && abort;
  assign lane_clr = go || kill;
  assign acc_en   = (state == ST_DATA) && in_valid && !abort;
  assign chk_en   = (state == ST_PAR)  && in_valid && !abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_count <= '0;
      mode      <= PAR_EVEN;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state     <= ST_IDLE;
        bit_count <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (go) begin
              state     <= ST_DATA;
              bit_count <= '0;
              mode      <= odd_mode;
              busy      <= 1'b1;
            end
          end
          ST_DATA: begin
            if (in_valid) begin
              bit_count <= bit_count + CNT_W'(1);
              if (bit_count == LAST_BIT) begin
                state <= ST_PAR;
              end
            end
          end
          ST_PAR: begin
            if (in_valid) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state     <= ST_IDLE;
            bit_count <= '0;
            mode      <= PAR_EVEN;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    serial_parity_checker_parity_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .clr      (lane_clr),
      .acc_en   (acc_en),
      .chk_en   (chk_en),
      .mode     (mode),
      .data_bit (in_bits[g]),
      .run_par  (run_par[g]),
      .err      (parity_err[g])
    );
  end

endmodule
